// File: rtl/p2s_ctrl_pkg.sv
// rtl/p2s_ctrl_pkg.sv - shared state encoding, default word width and width helper for the p2s readout controller
package p2s_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_REQ   = S_REQ,
        ST_WAIT  = S_WAIT,
        ST_LOAD  = S_LOAD,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } p2s_state_e;

    localparam int DEFAULT_WORD_W = 16;

    // Bits needed to count 0..value-1, never less than one so counters stay legal.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p2s_rd_timer.sv
// rtl/p2s_rd_timer.sv - MRAM read timeout down-counter (clear reloads, enable counts, expired flags the last waiting cycle)
module p2s_rd_timer
    import p2s_ctrl_pkg::*;
#(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = clog2_min1(TMO_CYC);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on clear, then count down once per enabled cycle and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // The TMO_CYC-th enabled cycle after a clear sees the counter at zero.
    assign expired = en && !clr && (cnt_q == '0);

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/p2s_readout_ctrl.sv
// rtl/p2s_readout_ctrl.sv - MRAM word fetch and p2s shifter sequencer; MRAM_TIMEOUT_EN adds a read timeout with sticky err
module p2s_readout_ctrl
    import p2s_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int WORD_W  = DEFAULT_WORD_W,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              mram_rd,
    output logic [ADDR_W-1:0] mram_addr,
    input  logic              mram_vld,
    output logic              p2s_en,
    output logic              p2s_load,
    output logic              p2s_send,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BIT_W = clog2_min1(WORD_W);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    p2s_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_last_q, tx_last_d;

`ifdef MRAM_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic err_q, err_d;

    // The timer is reloaded while the read strobe is out and runs only while waiting for data.
    assign tmr_clr = (state_q == ST_REQ);
    assign tmr_en  = (state_q == ST_WAIT);

    p2s_rd_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_rd_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign err = err_q;
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = (TMO_CYC != 0);
    assign err = 1'b0;
`endif

    // Strobes decode straight from the state so load and send can never overlap.
    assign mram_rd   = (state_q == ST_REQ);
    assign p2s_load  = (state_q == ST_LOAD);
    assign p2s_send  = (state_q == ST_SHIFT);
    assign busy      = (state_q != ST_IDLE);
    assign p2s_en    = busy;
    assign done      = (state_q == ST_DONE);
    assign mram_addr = addr_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;

    // Next-state, counter and flag logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        bit_cnt_d    = bit_cnt_q;
`ifdef MRAM_TIMEOUT_EN
        err_d        = err_q;
`endif
        // The shifter output is registered, so a send this cycle is a valid bit next cycle.
        tx_valid_d = p2s_send && !abort;
        tx_last_d  = p2s_send && !abort && (bit_cnt_q == BIT_LAST)
                     && (words_left_q == CNT_ONE);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
`ifdef MRAM_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (word_cnt != '0) begin
                        addr_d       = base_addr;
                        words_left_d = word_cnt;
                        state_d      = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mram_vld) begin
                    state_d = ST_LOAD;
`ifdef MRAM_TIMEOUT_EN
                end else if (tmr_expired) begin
                    err_d        = 1'b1;
                    words_left_d = '0;
                    state_d      = ST_DONE;
`endif
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (words_left_q > CNT_ONE) begin
                        // Address wraps naturally at the top of the MRAM word space.
                        addr_d       = addr_q + ADDR_ONE;
                        words_left_d = words_left_q - CNT_ONE;
                        state_d      = ST_REQ;
                    end else begin
                        words_left_d = '0;
                        state_d      = ST_DONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
`ifdef MRAM_TIMEOUT_EN
            err_d     = err_q;
`endif
        end
    end

    // State, counters and registered serial flags with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
`ifdef MRAM_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
`ifdef MRAM_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_p2s_readout_ctrl.sv
// tb/tb_p2s_readout_ctrl.sv - self-checking bench for p2s_readout_ctrl (timeout case only with MRAM_TIMEOUT_EN)
module tb_p2s_readout_ctrl;

    typedef struct packed {
        logic       rd;
        logic [9:0] addr;
        logic       load;
        logic       send;
        logic       txv;
        logic       txl;
        logic       busy;
        logic       en;
        logic       done;
        logic       err;
    } rec_t;

    localparam int K_RD = 0, K_LOAD = 1, K_SEND = 2, K_TXV = 3, K_TXL = 4, K_DONE = 5, K_BUSY = 6;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [9:0] base_addr;
    logic [7:0] word_cnt;
    logic       mram_rd, mram_vld;
    logic [9:0] mram_addr;
    logic       p2s_en, p2s_load, p2s_send, tx_valid, tx_last, busy, done, err;

    logic [15:0] mram_data;
    logic [15:0] sh_sr;
    logic        sh_out;
    logic [15:0] rx_sr = '0;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    bit   mute    = 1'b0;
    int   mram_lat = 1;
    logic [9:0] last_addr = '0;
    logic       exp_err   = 1'b0;
    int   overlap = 0;

    rec_t        exp_q[$];
    rec_t        tr[$];
    logic        ser_q[$];
    logic [15:0] words[$];
    logic [9:0]  rd_log[$];
    int          cnt_now[7];
    int          snap[7];
    int          log_base;

    p2s_readout_ctrl #(
        .ADDR_W (10),
        .CNT_W  (8),
        .WORD_W (16),
        .TMO_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .mram_rd  (mram_rd),
        .mram_addr(mram_addr),
        .mram_vld (mram_vld),
        .p2s_en   (p2s_en),
        .p2s_load (p2s_load),
        .p2s_send (p2s_send),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [9:0] a);
        if (a == 10'h010) return 16'hA5C3;
        return 16'h3C96 ^ {a, a[9:4]};
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.addr = last_addr;
        r.err  = exp_err;
        return r;
    endfunction

    // Behavioural 16-bit shifter: registered MSB-first output
    always @(posedge clk) begin
        if (p2s_load) begin
            sh_sr <= mram_data;
        end else if (p2s_send) begin
            sh_out <= sh_sr[15];
            sh_sr  <= {sh_sr[14:0], 1'b0};
        end
    end

    // MRAM read port model: data valid mram_lat cycles after the strobe
    initial begin
        logic [9:0] a;
        mram_vld  = 1'b0;
        mram_data = '0;
        forever begin
            @(negedge clk);
            if (mram_rd === 1'b1 && !mute) begin
                a = mram_addr;
                repeat (mram_lat) @(posedge clk);
                #1;
                mram_data = mem_word(a);
                mram_vld  = 1'b1;
                @(posedge clk);
                #1;
                mram_vld = 1'b0;
            end
        end
    end

    // Per-cycle compare against the expected trace, serial bit check and event counters
    initial begin
        rec_t act, e;
        logic b;
        for (int k = 0; k < 7; k++) cnt_now[k] = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = {mram_rd, mram_addr, p2s_load, p2s_send, tx_valid, tx_last, busy, p2s_en, done, err};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t got rd=%b addr=%h ld=%b snd=%b txv=%b txl=%b busy=%b en=%b done=%b err=%b expected rd=%b addr=%h ld=%b snd=%b txv=%b txl=%b busy=%b en=%b done=%b err=%b",
                             $time, act.rd, act.addr, act.load, act.send, act.txv, act.txl, act.busy, act.en, act.done, act.err,
                             e.rd, e.addr, e.load, e.send, e.txv, e.txl, e.busy, e.en, e.done, e.err);
                end
                if (tx_valid === 1'b1) begin
                    n_tests++;
                    if (ser_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL serial_extra t=%0t got bit %b expected no valid bit", $time, sh_out);
                    end else begin
                        b = ser_q.pop_front();
                        if (sh_out !== b) begin
                            n_fail++;
                            $display("FAIL serial_bit t=%0t got %b expected %b", $time, sh_out, b);
                        end
                    end
                    rx_sr = {rx_sr[14:0], sh_out};
                end
                if (mram_rd === 1'b1) begin
                    cnt_now[K_RD]++;
                    rd_log.push_back(mram_addr);
                end
                if (p2s_load === 1'b1) cnt_now[K_LOAD]++;
                if (p2s_send === 1'b1) cnt_now[K_SEND]++;
                if (tx_valid === 1'b1) cnt_now[K_TXV]++;
                if (tx_last === 1'b1) cnt_now[K_TXL]++;
                if (done === 1'b1) cnt_now[K_DONE]++;
                if (busy === 1'b1) cnt_now[K_BUSY]++;
                if (p2s_load === 1'b1 && p2s_send === 1'b1) overlap++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic take_snap();
        for (int k = 0; k < 7; k++) snap[k] = cnt_now[k];
        log_base = rd_log.size();
    endtask

    function automatic int dlt(input int k);
        return cnt_now[k] - snap[k];
    endfunction

    // Expected cycle trace of a burst, starting with the cycle in which start is driven
    task automatic build(input logic [9:0] base, input int cnt, input int lat, input bit tmo);
        rec_t r;
        logic [9:0] a;
        tr.delete();
        words.delete();
        tr.push_back(idle_rec());
        r = '0;
        r.busy = 1'b1;
        r.en   = 1'b1;
        if (cnt == 0) begin
            r.addr = last_addr;
            r.done = 1'b1;
            tr.push_back(r);
            return;
        end
        a = base;
        for (int w = 0; w < cnt; w++) begin
            a = base + 10'(w);
            words.push_back(mem_word(a));
            r.addr = a;
            r.rd = 1'b1;
            tr.push_back(r);
            r.rd = 1'b0;
            for (int i = 0; i < lat; i++) tr.push_back(r);
            if (tmo) begin
                r.done = 1'b1;
                r.err  = 1'b1;
                tr.push_back(r);
                return;
            end
            r.load = 1'b1;
            tr.push_back(r);
            r.load = 1'b0;
            r.send = 1'b1;
            for (int i = 0; i < 16; i++) tr.push_back(r);
            r.send = 1'b0;
        end
        r.done = 1'b1;
        tr.push_back(r);
    endtask

    // Derive the delayed serial flags, cut the trace if the burst is interrupted, queue it
    task automatic commit(input int keep, input bit by_reset);
        rec_t r;
        int last_send, n;
        logic [15:0] wv;
        last_send = -1;
        for (int i = 0; i < tr.size(); i++) if (tr[i].send) last_send = i;
        for (int i = tr.size() - 1; i >= 1; i--) begin
            r = tr[i];
            r.txv = tr[i-1].send;
            r.txl = (last_send >= 0) && (i == last_send + 1);
            tr[i] = r;
        end
        if (keep >= 0) begin
            while (tr.size() > keep) void'(tr.pop_back());
        end
        n = 0;
        for (int i = 0; i < tr.size(); i++) if (tr[i].txv) n++;
        for (int k = 0; k < n; k++) begin
            wv = words[k / 16];
            ser_q.push_back(wv[15 - (k % 16)]);
        end
        for (int i = 0; i < tr.size(); i++) exp_q.push_back(tr[i]);
        if (by_reset) begin
            last_addr = '0;
            exp_err   = 1'b0;
        end else begin
            last_addr = tr[tr.size()-1].addr;
            exp_err   = tr[tr.size()-1].err;
        end
    endtask

    task automatic start_burst(input logic [9:0] base, input logic [7:0] cnt);
        base_addr = base;
        word_cnt  = cnt;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            tick();
            c++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending cycles expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
        chk("serial_drained", ser_q.size(), 0);
        ser_q.delete();
    endtask

    initial begin
        int ns, ab;
        rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_cnt = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_outputs", {mram_rd, mram_addr, p2s_en, p2s_load, p2s_send, tx_valid, tx_last, busy, done, err}, 0);
        rst = 1'b1;
        tick();

        // single word 0x010 -> 0xA5C3, read latency 2
        take_snap();
        mram_lat = 2;
        build(10'h010, 1, 2, 1'b0);
        commit(-1, 1'b0);
        start_burst(10'h010, 8'd1);
        drain();
        chk("single_rd_count", dlt(K_RD), 1);
        chk("single_rd_addr", rd_log[log_base], 10'h010);
        chk("single_load_count", dlt(K_LOAD), 1);
        chk("single_send_count", dlt(K_SEND), 16);
        chk("single_txv_count", dlt(K_TXV), 16);
        chk("single_txl_count", dlt(K_TXL), 1);
        chk("single_done_count", dlt(K_DONE), 1);
        chk("single_serial_word", rx_sr, 16'hA5C3);

        // three-word burst wrapping the address space, latency 1
        take_snap();
        mram_lat = 1;
        build(10'h3FE, 3, 1, 1'b0);
        commit(-1, 1'b0);
        start_burst(10'h3FE, 8'd3);
        drain();
        chk("wrap_rd_count", dlt(K_RD), 3);
        chk("wrap_addr0", rd_log[log_base], 10'h3FE);
        chk("wrap_addr1", rd_log[log_base+1], 10'h3FF);
        chk("wrap_addr2", rd_log[log_base+2], 10'h000);
        chk("wrap_txv_count", dlt(K_TXV), 48);
        chk("wrap_done_count", dlt(K_DONE), 1);

        // zero-length request
        take_snap();
        build(10'h3AA, 0, 1, 1'b0);
        commit(-1, 1'b0);
        start_burst(10'h3AA, 8'd0);
        drain();
        chk("zero_rd_count", dlt(K_RD), 0);
        chk("zero_load_count", dlt(K_LOAD), 0);
        chk("zero_send_count", dlt(K_SEND), 0);
        chk("zero_busy_cycles", dlt(K_BUSY), 1);
        chk("zero_done_count", dlt(K_DONE), 1);

        // four-word burst: ignored start while busy, abort on the 5th send of word 2
        take_snap();
        mram_lat = 2;
        build(10'h100, 4, 2, 1'b0);
        ns = 0;
        ab = -1;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].send) begin
                ns++;
                if (ns == 21 && ab < 0) ab = i;
            end
        end
        commit(ab + 1, 1'b0);
        start_burst(10'h100, 8'd4);
        tick();
        tick();
        start_burst(10'h200, 8'd1);
        repeat (ab - 4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain();
        chk("abort_rd_count", dlt(K_RD), 2);
        chk("abort_addr0", rd_log[log_base], 10'h100);
        chk("abort_addr1", rd_log[log_base+1], 10'h101);
        chk("abort_send_count", dlt(K_SEND), 21);
        chk("abort_txv_count", dlt(K_TXV), 20);
        chk("abort_done_count", dlt(K_DONE), 0);

        // abort and start together in IDLE: nothing happens
        take_snap();
        base_addr = 10'h111;
        word_cnt  = 8'd2;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) tick();
        chk("abort_start_busy", dlt(K_BUSY), 0);
        chk("abort_start_rd", dlt(K_RD), 0);

        // reset pulse on the 3rd send of word 1
        take_snap();
        mram_lat = 1;
        build(10'h020, 2, 1, 1'b0);
        commit(7, 1'b1);
        start_burst(10'h020, 8'd2);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("reset_mid_outputs", {mram_rd, mram_addr, p2s_en, p2s_load, p2s_send, tx_valid, tx_last, busy, done, err}, 0);
        drain();
        chk("reset_done_count", dlt(K_DONE), 0);

`ifdef MRAM_TIMEOUT_EN
        // read never answered: timeout after 8 waiting cycles, next start clears err
        take_snap();
        mute = 1'b1;
        build(10'h055, 1, 8, 1'b1);
        commit(-1, 1'b0);
        start_burst(10'h055, 8'd1);
        drain();
        chk("tmo_err_set", err, 1);
        chk("tmo_done_count", dlt(K_DONE), 1);
        mute = 1'b0;
        mram_lat = 1;
        build(10'h056, 1, 1, 1'b0);
        commit(-1, 1'b0);
        start_burst(10'h056, 8'd1);
        drain();
        chk("tmo_err_cleared", err, 0);
`endif

        chk("load_send_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
